// File: rtl/nonrestoring_divider.sv
// Iterative non-restoring divider: one add/subtract of the partial remainder per cycle, with a
// sign-fix stage. Optional overflow flag output when DIVIDER_OVF_FLAG_EN is defined.
module nonrestoring_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             signed_op,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
`ifdef DIVIDER_OVF_FLAG_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [WIDTH-1:0] r_dvd;      // dividend bits shift out MSB-first, quotient bits shift in
    logic [WIDTH-1:0] r_dsr;
    logic [WIDTH:0]   r_rem;
    logic [CW-1:0]    r_cnt;
    logic             r_sign_n;
    logic             r_sign_d;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_remd;
    logic             r_dbz;
    logic             r_ovf;

    logic             w_div_zero;
    logic             w_ovf_case;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dsr_mag;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_rem_step;
    logic             w_qbit;
    logic [WIDTH:0]   w_rem_fix;
    logic [WIDTH-1:0] w_q_out;
    logic [WIDTH-1:0] w_r_out;

    assign w_div_zero = (divisor == '0);
    assign w_ovf_case = signed_op && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
    assign w_dvd_mag  = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
    assign w_dsr_mag  = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;

    assign w_shift    = {r_rem[WIDTH-1:0], r_dvd[WIDTH-1]};
    assign w_rem_step = r_rem[WIDTH] ? (w_shift + {1'b0, r_dsr}) : (w_shift - {1'b0, r_dsr});
    assign w_qbit     = ~w_rem_step[WIDTH];

    assign w_rem_fix  = r_rem[WIDTH] ? (r_rem + {1'b0, r_dsr}) : r_rem;
    assign w_q_out    = (r_sign_n ^ r_sign_d) ? -r_dvd : r_dvd;
    assign w_r_out    = r_sign_n ? -w_rem_fix[WIDTH-1:0] : w_rem_fix[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_valid) begin
                    w_state_next = w_div_zero ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == '0) begin
                    w_state_next = S_FIX;
                end
            end
            S_FIX: begin
                w_state_next = S_DONE;
            end
            S_DONE: begin
                if (res_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dvd    <= '0;
            r_dsr    <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_sign_n <= 1'b0;
            r_sign_d <= 1'b0;
            r_quot   <= '0;
            r_remd   <= '0;
            r_dbz    <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_valid) begin
                        r_dvd    <= w_dvd_mag;
                        r_dsr    <= w_dsr_mag;
                        r_rem    <= '0;
                        r_cnt    <= CW'(WIDTH - 1);
                        r_sign_n <= signed_op & dividend[WIDTH-1];
                        r_sign_d <= signed_op & divisor[WIDTH-1];
                        r_ovf    <= w_ovf_case;
                        r_dbz    <= w_div_zero;
                        if (w_div_zero) begin
                            r_quot <= '1;
                            r_remd <= dividend;
                        end
                    end
                end
                S_CALC: begin
                    r_rem <= w_rem_step;
                    r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
                    r_cnt <= r_cnt - CW'(1);
                end
                S_FIX: begin
                    r_quot <= w_q_out;
                    r_remd <= w_r_out;
                end
                default: begin
                end
            endcase
        end
    end

    assign start_ready = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign res_valid   = (r_state == S_DONE);
    assign quotient    = r_quot;
    assign remainder   = r_remd;
    assign div_by_zero = r_dbz;
`ifdef DIVIDER_OVF_FLAG_EN
    assign ovf         = r_ovf;
`else
    logic w_ovf_unused;
    assign w_ovf_unused = r_ovf;
`endif

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Randomised and directed bench for nonrestoring_divider against an arithmetic reference model.
module tb_nonrestoring_divider;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        signed_op = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;
    logic        busy;
`ifdef DIVIDER_OVF_FLAG_EN
    logic        ovf;
`endif

    int n_total = 0;
    int n_bad = 0;
    int n_op = 0;

    always #5 clk = ~clk;

    nonrestoring_divider #(.WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .dividend(dividend),
        .divisor(divisor),
        .signed_op(signed_op),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero),
`ifdef DIVIDER_OVF_FLAG_EN
        .ovf(ovf),
`endif
        .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic z, output logic ov);
        longint sa, sb, ua, ub;
        z  = 1'b0;
        ov = 1'b0;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            z = 1'b1;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q  = 32'h8000_0000;
                r  = 32'd0;
                ov = 1'b1;
            end else begin
                q = 32'(sa / sb);
                r = 32'(sa % sb);
            end
        end else begin
            ua = longint'({32'd0, a});
            ub = longint'({32'd0, b});
            q = 32'(ua / ub);
            r = 32'(ua % ub);
        end
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (!start_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!start_ready) check("idle_timeout", 32'd0, 32'd1);
    endtask

    // Returns latency in edges from the accept edge to the edge that first samples res_valid.
    task automatic wait_result(output int lat);
        int n = 0;
        @(negedge clk);
        while (!res_valid && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!res_valid) check("result_timeout", 32'd0, 32'd1);
        lat = n + 1;
    endtask

    task automatic accept(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge clk);
        wait_idle();
        start_valid = 1'b1;
        dividend    = a;
        divisor     = b;
        signed_op   = s;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        dividend    = $urandom;
        divisor     = $urandom;
        signed_op   = ~s;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
    endtask

    task automatic release_result();
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        check("idle_after_release", {31'd0, start_ready}, 32'd1);
    endtask

    task automatic check_result(input logic [31:0] a, input logic [31:0] b, input logic s, input int lat);
        logic [31:0] eq, er;
        logic ez, eo;
        model(a, b, s, eq, er, ez, eo);
        n_op++;
        $display("op %0d: %h / %h signed=%0d -> q=%h r=%h z=%0d lat=%0d", n_op, a, b, s,
                 quotient, remainder, div_by_zero, lat);
        check("quotient", quotient, eq);
        check("remainder", remainder, er);
        check("div_by_zero", {31'd0, div_by_zero}, {31'd0, ez});
        check("latency", lat, ez ? 32'd1 : 32'd34);
`ifdef DIVIDER_OVF_FLAG_EN
        check("ovf", {31'd0, ovf}, {31'd0, eo});
`endif
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s);
        int lat;
        accept(a, b, s);
        wait_result(lat);
        check_result(a, b, s, lat);
        release_result();
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        logic [31:0] hq, hr;
        int          lat;

        #1;
        check("rst_start_ready", {31'd0, start_ready}, 32'd1);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_quotient", quotient, 32'd0);
        check("rst_remainder", remainder, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op(32'd100, 32'd7, 1'b0);
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1);
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1);
        run_op(32'h1234_5678, 32'd0, 1'b0);
        run_op(32'h1234_5678, 32'd0, 1'b1);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

        // Result held under back-pressure while a second request waits.
        accept(32'd1000, 32'd3, 1'b0);
        wait_result(lat);
        check_result(32'd1000, 32'd3, 1'b0, lat);
        hq = quotient;
        hr = remainder;
        start_valid = 1'b1;
        dividend    = 32'd50;
        divisor     = 32'd5;
        signed_op   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_quotient", quotient, hq);
            check("hold_remainder", remainder, hr);
            check("hold_start_ready", {31'd0, start_ready}, 32'd0);
            check("hold_res_valid", {31'd0, res_valid}, 32'd1);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        check("release_idle", {31'd0, start_ready}, 32'd1);
        check("release_valid_low", {31'd0, res_valid}, 32'd0);
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        check("second_accepted", {31'd0, busy}, 32'd1);
        wait_result(lat);
        check_result(32'd50, 32'd5, 1'b0, lat);
        release_result();

        // Abort during the iteration phase.
        accept(32'hDEAD_BEEF, 32'd3, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_start_ready", {31'd0, start_ready}, 32'd1);
        check("abort_res_valid", {31'd0, res_valid}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_quotient", quotient, 32'd0);
        check("abort_remainder", remainder, 32'd0);
        check("abort_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            rs = 1'(i & 1);
            case (i % 10)
                0: rb = 32'd0;
                1: rb = 32'd1;
                2: rb = 32'hFFFF_FFFF;
                3: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                4: ra = $urandom_range(0, 20);
                default: begin end
            endcase
            run_op(ra, rb, rs);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
